opc6_iotimer: RTL and testbench
===============================

# opc6_iotimer

I/O-space countdown timer that responds to OPC6 `IN`/`OUT` bus cycles and raises a level interrupt for the CPU's `int_b[0]` input. It decodes an aligned 8-word window in I/O space (`vio` high) and returns read data combinationally in the same cycle, so the CPU's read state latches it at the next edge. It accepts writes on the clock edge where `rnw` is low and `clken` is high. One instance sits beside memory on the system bus; its `dout` is ORed/muxed into the CPU `din` under `sel`.

## Interface
- `BASE`, 16'hFE00: I/O base address; bits [2:0] must be 0.
- `RESET_RELOAD`, 16'h0000: reset value of RELOAD.
- `clk`  in  1: system clock; same clock as the CPU.
- `reset`  in  1: synchronous, active-high reset.
- `clken`  in  1: global clock enable. All state updates are qualified by it.
- `address`  in  16: CPU address bus.
- `din`  in  16: CPU write data (CPU `dout`).
- `rnw`  in  1: 1 = read, 0 = write.
- `vio`  in  1: I/O cycle valid.
- `dout`  out  16: read data, combinational; 0 when `sel` is low.
- `sel`  out  1: `vio & (address[15:3]==BASE[15:3])`.
- `irq_b`  out  1: active-low level interrupt; intended for `int_b[0]`.

## Operation
- Registers, at offset `address[2:0]`:
  - 0 CTRL[2:0]: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable). Read returns {13'b0,CTRL}.
  - 1 STATUS: bit0 EXP (expired flag), bit1 RUN (=EN). Writing 1 to bit0 clears EXP; other bits are ignored.
  - 2 RELOAD[15:0]: read/write.
  - 3 COUNT[15:0]: read returns the live count. A write loads COUNT and clears the prescaler counter.
  - 4 PRE[7:0]: exists only with the macro; see Configuration.
  - 5–7: read 0; writes are ignored.
- Write strobe `we = clken & sel & !rnw`. Reads have no side effects.
- Two-state FSM, held in CTRL.EN:
  - STOP (EN=0): COUNT holds.
  - RUN (EN=1): COUNT decrements once per tick.
  - STOP→RUN only by a CPU write of EN=1.
  - RUN→STOP by a CPU write of EN=0, or by one-shot expiry.
- Tick: `clken & EN & prescale_terminal`. Without the macro, `prescale_terminal=1`.
- On a tick, COUNT is updated as follows:
  - COUNT==0: no change, no event.
  - COUNT==1: expiry. EXP<=1. If AUTO, COUNT<=RELOAD; otherwise COUNT<=0 and EN<=0.
  - Otherwise: COUNT<=COUNT-1, 16-bit unsigned, no wrap possible.
- Auto-reload period is RELOAD ticks. RELOAD=0 with AUTO gives one expiry, then COUNT parks at 0.
- `irq_b = !(EXP & IE)`. It stays low until software clears EXP or IE.

## Timing
- Read latency 0: `dout` is valid in the cycle `address`/`vio` are valid.
- Write latency 1: the register takes `din` at the edge with `we`; the new value is visible on `dout` the following cycle.
- Expiry edge: EXP, and therefore `irq_b`, change at the same edge as the COUNT 1→0/reload transition.
- Collision rules for the same edge:
  - COUNT write and tick: the write wins and the tick is discarded.
  - CTRL write and expiry: the CTRL write wins for EN and AUTO; EXP is still set.
  - EXP write-1-clear and a new expiry: set wins, EXP=1.
  - RELOAD write and auto-reload expiry: COUNT loads the old RELOAD.
- `clken` low: all state frozen, including the prescaler; writes are ignored.
- Reset, sampled on `clk` regardless of `clken`, including mid-count: CTRL=0, EXP=0, COUNT=0, RELOAD=`RESET_RELOAD`, PRE=0, prescaler counter=0. Outputs after reset: `irq_b`=1; `dout`=0 unless selected.

## Configuration
- `OPC6_IOTIMER_PRESCALE_EN`:
  - Defined: PRE register at offset 4 (8-bit, read {8'b0,PRE}) and an 8-bit prescaler counter PC.
    - PC advances on `clken & EN`.
    - When PC==PRE: `prescale_terminal=1` and PC<=0; otherwise PC<=PC+1.
    - The tick rate is therefore `clken`/(PRE+1).
    - PC clears on a COUNT write and whenever EN=0.
  - Undefined: no PRE register and no prescaler. Offset 4 reads 0 and writes are ignored. A tick occurs on every `clken & EN` cycle.

## Test plan
- Reset, then read offsets 0–3 via `vio` reads. Expect CTRL=0, STATUS=0, RELOAD=`RESET_RELOAD`, COUNT=0, `irq_b`=1. Repeat with `vio`=0 and expect `sel`=0, `dout`=0.
- One-shot: write COUNT=3, then CTRL=3'b101, with `clken` held high and no prescale.
  - Expect COUNT 3,2,1,0 on successive cycles.
  - Expect EXP=1 and `irq_b`=0 on the third tick, and EN=0 afterwards.
  - Write STATUS=1 and expect `irq_b`=1.
- Auto-reload: RELOAD=4, COUNT=4, CTRL=3'b111. Expect expiries exactly every 4 cycles across 3 periods; EXP is sticky.
- Collisions:
  - COUNT write of 16'h0010 on the cycle COUNT==1: expect COUNT=16'h0010 and no expiry.
  - STATUS clear on an expiry cycle: expect EXP=1.
- `clken` toggled 1/0 during a count: COUNT changes only on `clken`=1 cycles. Reset asserted mid-count: all registers reach reset values next edge, and `irq_b`=1.
- With `OPC6_IOTIMER_PRESCALE_EN`: PRE=2, COUNT=2, EN=1. Expect expiry after 6 `clken` cycles. Without the macro, offset 4 reads 0 after writing 16'h00FF.

Source files
------------

// File: rtl/opc6_iotimer.sv
// opc6_iotimer: OPC6 I/O-space countdown timer with active-low level irq; optional prescaler under OPC6_IOTIMER_PRESCALE_EN.
// Reads are combinational (latency 0), writes land at the next clken edge (latency 1); the bus is never stalled.
module opc6_iotimer #(
   parameter logic [15:0] BASE         = 16'hFE00,
   parameter logic [15:0] RESET_RELOAD = 16'h0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clken_i,
   input  logic [15:0] address_i,
   input  logic [15:0] din_i,
   input  logic        rnw_i,
   input  logic        vio_i,
   output logic [15:0] dout_o,
   output logic        sel_o,
   output logic        irq_b_o
);

   typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_e;

   state_e      state_q, state_d;
   logic        auto_q, auto_d;
   logic        ie_q, ie_d;
   logic        exp_q, exp_d;
   logic [15:0] reload_q, reload_d;
   logic [15:0] count_q, count_d;

   logic [2:0]  off;
   logic        we;
   logic        wr_ctrl, wr_stat, wr_rel, wr_cnt;
   logic        en;
   logic        terminal;
   logic        tick;
   logic        expire;
   logic [15:0] rd_dat;

   assign off     = address_i[2:0];
   assign sel_o   = vio_i & (address_i[15:3] == BASE[15:3]);
   assign we      = clken_i & sel_o & ~rnw_i;
   assign wr_ctrl = we & (off == 3'd0);
   assign wr_stat = we & (off == 3'd1);
   assign wr_rel  = we & (off == 3'd2);
   assign wr_cnt  = we & (off == 3'd3);

   assign tick   = clken_i & en & terminal;
   // A COUNT write on the same edge swallows the tick, so it cannot expire either.
   assign expire = tick & (count_q == 16'd1) & ~wr_cnt;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_STOP;
      end else if (clken_i) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (wr_ctrl && din_i[0]) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (wr_ctrl)                state_d = din_i[0] ? ST_RUN : ST_STOP;
            else if (expire && !auto_q) state_d = ST_STOP;
         end
         default: state_d = ST_STOP;
      endcase
   end

   always_comb begin
      en = (state_q == ST_RUN);
   end

`ifdef OPC6_IOTIMER_PRESCALE_EN
   logic       wr_pre;
   logic [7:0] pre_q, pre_d;
   logic [7:0] pc_q, pc_d;

   assign wr_pre   = we & (off == 3'd4);
   assign terminal = (pc_q == pre_q);

   always_comb begin
      pre_d = pre_q;
      if (wr_pre) pre_d = din_i[7:0];
      pc_d = pc_q;
      if (wr_cnt || !en)  pc_d = 8'd0;
      else if (terminal)  pc_d = 8'd0;
      else                pc_d = pc_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pre_q <= 8'd0;
         pc_q  <= 8'd0;
      end else if (clken_i) begin
         pre_q <= pre_d;
         pc_q  <= pc_d;
      end
   end
`else
   assign terminal = 1'b1;
`endif

   always_comb begin
      auto_d   = wr_ctrl ? din_i[1] : auto_q;
      ie_d     = wr_ctrl ? din_i[2] : ie_q;
      reload_d = wr_rel  ? din_i    : reload_q;

      // Set beats write-1-clear when both land on one edge.
      exp_d = exp_q;
      if (wr_stat && din_i[0]) exp_d = 1'b0;
      if (expire)              exp_d = 1'b1;

      count_d = count_q;
      if (wr_cnt) begin
         count_d = din_i;
      end else if (tick) begin
         if (count_q == 16'd1)      count_d = auto_q ? reload_q : 16'd0;
         else if (count_q != 16'd0) count_d = count_q - 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         auto_q   <= 1'b0;
         ie_q     <= 1'b0;
         exp_q    <= 1'b0;
         reload_q <= RESET_RELOAD;
         count_q  <= 16'd0;
      end else if (clken_i) begin
         auto_q   <= auto_d;
         ie_q     <= ie_d;
         exp_q    <= exp_d;
         reload_q <= reload_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      rd_dat = 16'd0;
      case (off)
         3'd0:    rd_dat = {13'd0, ie_q, auto_q, en};
         3'd1:    rd_dat = {14'd0, en, exp_q};
         3'd2:    rd_dat = reload_q;
         3'd3:    rd_dat = count_q;
`ifdef OPC6_IOTIMER_PRESCALE_EN
         3'd4:    rd_dat = {8'd0, pre_q};
`endif
         default: rd_dat = 16'd0;
      endcase
   end

   assign dout_o  = sel_o ? rd_dat : 16'd0;
   assign irq_b_o = ~(exp_q & ie_q);

endmodule

// File: tb/tb_opc6_iotimer.sv
// Directed bench for opc6_iotimer: register table, then one-shot/auto/collision/clken/reset sequences.
module tb_opc6_iotimer;

   localparam logic [15:0] BASE = 16'hFE00;

   logic        clk = 1'b0;
   logic        reset;
   logic        clken;
   logic [15:0] address;
   logic [15:0] din;
   logic        rnw;
   logic        vio;
   logic [15:0] dout;
   logic        sel;
   logic        irq_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   opc6_iotimer #(
      .BASE         (BASE),
      .RESET_RELOAD (16'h0000)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .clken_i   (clken),
      .address_i (address),
      .din_i     (din),
      .rnw_i     (rnw),
      .vio_i     (vio),
      .dout_o    (dout),
      .sel_o     (sel),
      .irq_b_o   (irq_b)
   );

   typedef struct {
      logic        vio;
      logic        rnw;
      logic        ce;
      logic [2:0]  off;
      logic [15:0] wd;
      logic [15:0] x_dout;
      logic        x_sel;
      logic        x_irq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic r, input logic ce, input logic [2:0] off,
                               input logic [15:0] wd, input logic [15:0] xd, input logic xs, input logic xi);
      vec_t t;
      t.vio = v; t.rnw = r; t.ce = ce; t.off = off; t.wd = wd;
      t.x_dout = xd; t.x_sel = xs; t.x_irq = xi;
      return t;
   endfunction

   // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic v, input logic r, input logic ce, input logic [2:0] off, input logic [15:0] d);
      @(negedge clk);
      vio     = v;
      rnw     = r;
      clken   = ce;
      address = BASE | {13'd0, off};
      din     = d;
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] xd, input logic xs, input logic xi);
      n_tests++;
      if (dout !== xd || sel !== xs || irq_b !== xi) begin
         n_fail++;
         $display("FAIL %s: got dout=%h sel=%b irq_b=%b, want dout=%h sel=%b irq_b=%b",
                  name, dout, sel, irq_b, xd, xs, xi);
      end
   endtask

   task automatic rd(input logic [2:0] off, input logic [15:0] xd, input logic xi, input string name);
      drive(1'b1, 1'b1, 1'b1, off, 16'd0);
      chk(name, xd, 1'b1, xi);
   endtask

   task automatic wr(input logic [2:0] off, input logic [15:0] d);
      drive(1'b1, 1'b0, 1'b1, off, d);
   endtask

   logic [15:0] pre_rb;
   logic [15:0] exp_cnt;

   initial begin
      reset = 1'b1; clken = 1'b1; address = BASE; din = 16'd0; rnw = 1'b1; vio = 1'b0;

`ifdef OPC6_IOTIMER_PRESCALE_EN
      pre_rb = 16'h00FF;
`else
      pre_rb = 16'h0000;
`endif
      vecs.push_back(mk(1,1,1,3'd0,16'h0000,16'h0000,1,1)); // reset CTRL
      vecs.push_back(mk(1,1,1,3'd1,16'h0000,16'h0000,1,1)); // reset STATUS
      vecs.push_back(mk(1,1,1,3'd2,16'h0000,16'h0000,1,1)); // reset RELOAD
      vecs.push_back(mk(1,1,1,3'd3,16'h0000,16'h0000,1,1)); // reset COUNT
      vecs.push_back(mk(0,1,1,3'd0,16'h0000,16'h0000,0,1)); // vio low
      vecs.push_back(mk(0,1,1,3'd3,16'h0000,16'h0000,0,1));
      vecs.push_back(mk(1,0,1,3'd3,16'h0003,16'h0000,1,1)); // COUNT=3
      vecs.push_back(mk(1,0,1,3'd0,16'h0005,16'h0000,1,1)); // CTRL=EN|IE
      vecs.push_back(mk(1,1,1,3'd3,16'h0000,16'h0003,1,1));
      vecs.push_back(mk(1,1,1,3'd3,16'h0000,16'h0002,1,1));
      vecs.push_back(mk(1,1,1,3'd3,16'h0000,16'h0001,1,1));
      vecs.push_back(mk(1,1,1,3'd3,16'h0000,16'h0000,1,0)); // expired
      vecs.push_back(mk(1,1,1,3'd1,16'h0000,16'h0001,1,0)); // EXP=1, RUN=0
      vecs.push_back(mk(1,1,1,3'd0,16'h0000,16'h0004,1,0)); // EN cleared
      vecs.push_back(mk(1,0,1,3'd1,16'h0001,16'h0001,1,0)); // clear EXP
      vecs.push_back(mk(1,1,1,3'd1,16'h0000,16'h0000,1,1));
      vecs.push_back(mk(1,0,1,3'd4,16'h00FF,16'h0000,1,1)); // offset 4 write
      vecs.push_back(mk(1,1,1,3'd4,16'h0000,pre_rb,1,1));
      vecs.push_back(mk(1,0,1,3'd4,16'h0000,pre_rb,1,1));   // PRE back to 0
      vecs.push_back(mk(1,0,1,3'd5,16'hFFFF,16'h0000,1,1)); // offset 5 ignored
      vecs.push_back(mk(1,1,1,3'd5,16'h0000,16'h0000,1,1));
      vecs.push_back(mk(1,0,1,3'd2,16'h0004,16'h0000,1,1)); // RELOAD=4
      vecs.push_back(mk(1,1,1,3'd2,16'h0000,16'h0004,1,1));
      vecs.push_back(mk(1,0,0,3'd2,16'h0009,16'h0004,1,1)); // clken low write
      vecs.push_back(mk(1,1,1,3'd2,16'h0000,16'h0004,1,1));

      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].vio, vecs[i].rnw, vecs[i].ce, vecs[i].off, vecs[i].wd);
         chk($sformatf("vec%0d", i), vecs[i].x_dout, vecs[i].x_sel, vecs[i].x_irq);
      end

      // Outside the 8-word window
      @(negedge clk);
      vio = 1'b1; rnw = 1'b1; clken = 1'b1; address = BASE + 16'h0008;
      #1;
      chk("out_of_window", 16'h0000, 1'b0, 1'b1);

      // Auto-reload, RELOAD=4: expiry every 4 ticks, EXP sticky
      wr(3'd3, 16'h0004);
      wr(3'd0, 16'h0007);
      for (int i = 0; i < 12; i++) begin
         rd(3'd3, 16'd4 - 16'(i % 4), (i >= 4) ? 1'b0 : 1'b1, $sformatf("auto%0d", i));
      end

      // COUNT write on the COUNT==1 cycle wins over expiry
      drive(1'b1, 1'b0, 1'b1, 3'd1, 16'h0001);
      chk("auto_clr", 16'h0003, 1'b1, 1'b0);
      rd(3'd3, 16'h0003, 1'b1, "pre_coll_a");
      rd(3'd3, 16'h0002, 1'b1, "pre_coll_b");
      drive(1'b1, 1'b0, 1'b1, 3'd3, 16'h0010);
      chk("coll_cnt_at1", 16'h0001, 1'b1, 1'b1);
      rd(3'd3, 16'h0010, 1'b1, "coll_cnt_val");
      rd(3'd1, 16'h0002, 1'b1, "coll_cnt_noexp");

      // STATUS clear on an expiry edge: set wins
      drive(1'b1, 1'b0, 1'b1, 3'd3, 16'h0002);
      chk("coll_st_ld", 16'h000E, 1'b1, 1'b1);
      rd(3'd3, 16'h0002, 1'b1, "coll_st_a");
      drive(1'b1, 1'b0, 1'b1, 3'd1, 16'h0001);
      chk("coll_st_b", 16'h0002, 1'b1, 1'b1);
      rd(3'd1, 16'h0003, 1'b0, "coll_st_exp");
      rd(3'd3, 16'h0003, 1'b0, "coll_st_reload");

      // clken toggling: COUNT moves only on clken=1 cycles
      wr(3'd3, 16'h0008);
      wr(3'd0, 16'h0001);
      exp_cnt = 16'h0007;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b1, 1'(k % 2), 3'd3, 16'd0);
         chk($sformatf("clken%0d", k), exp_cnt, 1'b1, 1'b1);
         if (k % 2 == 1) exp_cnt = exp_cnt - 16'd1;
      end

      // Reset mid-count with irq asserted
      wr(3'd0, 16'h0005);
      wr(3'd3, 16'h0001);
      rd(3'd3, 16'h0001, 1'b0, "pre_rst_cnt");
      rd(3'd1, 16'h0001, 1'b0, "pre_rst_exp");
      @(negedge clk);
      reset = 1'b1; clken = 1'b0; vio = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_irq", 16'h0000, 1'b0, 1'b1);
      for (int o = 0; o < 4; o++) begin
         rd(3'(o), 16'h0000, 1'b1, $sformatf("rst_off%0d", o));
      end

`ifdef OPC6_IOTIMER_PRESCALE_EN
      // PRE=2, COUNT=2: expiry after 6 clken cycles
      wr(3'd4, 16'h0002);
      wr(3'd3, 16'h0002);
      wr(3'd0, 16'h0001);
      for (int c = 1; c <= 6; c++) begin
         rd(3'd1, 16'h0002, 1'b1, $sformatf("pre_c%0d", c));
      end
      rd(3'd1, 16'h0001, 1'b1, "pre_expired");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
